// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment patterns are {a,b,c,d,e,f,g}, active-low (0 = segment lit).
package seven_seg_pkg;

  typedef logic [3:0] digit_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

endpackage

// File: rtl/seven_segment_scan_if.sv
// Host-side bundle of the scan driver: control/data towards it, display drive back.
interface seven_segment_scan_if #(
  parameter int NUM_DIGITS = 4
);

  logic                      en;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   digits_in;
  logic [6:0]                seg;
  logic [NUM_DIGITS-1:0]     an;
  logic                      frame_done;

  modport master (
    output en, load, digits_in,
    input  seg, an, frame_done
  );

  modport slave (
    input  en, load, digits_in,
    output seg, an, frame_done
  );

endinterface

// File: rtl/seven_seg_decode.sv
// Combinational 4-bit code to active-low segment pattern; codes 10..15
// show A..F only when hex_en is set, otherwise they are blank.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  digit_t     code,
  input  logic       hex_en,
  output logic [6:0] pattern
);

  // Code lookup; hex letters gated by hex_en
  always_comb begin
    pattern = SEG_BLANK;
    case (code)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      4'd10:   pattern = hex_en ? SEG_A : SEG_BLANK;
      4'd11:   pattern = hex_en ? SEG_B : SEG_BLANK;
      4'd12:   pattern = hex_en ? SEG_C : SEG_BLANK;
      4'd13:   pattern = hex_en ? SEG_D : SEG_BLANK;
      4'd14:   pattern = hex_en ? SEG_E : SEG_BLANK;
      4'd15:   pattern = hex_en ? SEG_F : SEG_BLANK;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan.sv
// Time-multiplexed multi-digit seven-segment driver (common anode, active-low).
// Optional leading-zero blanking when SEVEN_SEG_LZB_EN is defined.
module seven_segment_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int HEX_MODE   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  seven_segment_scan_if.slave  bus
);

  localparam int              PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int              IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0]   IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic            HEX_EN   = (HEX_MODE != 0);

  logic [PW-1:0]             prescaler_r;
  logic [IW-1:0]             idx_r;
  logic [4*NUM_DIGITS-1:0]   digits_r;
  logic [6:0]                seg_r;
  logic [NUM_DIGITS-1:0]     an_r;
  logic                      frame_done_r;

  logic                      tick_s;
  logic [IW-1:0]             next_idx_s;
  digit_t                    code_s;
  logic [6:0]                pattern_s;
  logic [6:0]                seg_next_s;
  logic [NUM_DIGITS-1:0]     an_next_s;
  logic                      blank_s;

  // Scan tick and the digit that becomes lit on it
  always_comb begin
    tick_s = bus.en && (prescaler_r == PRE_LAST);
    if (idx_r == IDX_LAST) begin
      next_idx_s = '0;
    end else begin
      next_idx_s = idx_r + IW'(1);
    end
  end

  // Select the latched code and one-cold anode for the upcoming digit
  always_comb begin
    code_s    = 4'd0;
    an_next_s = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (next_idx_s == IW'(i)) begin
        code_s       = digits_r[4*i +: 4];
        an_next_s[i] = 1'b0;
      end else begin
        an_next_s[i] = 1'b1;
      end
    end
  end

  seven_seg_decode u_decode (
    .code    (code_s),
    .hex_en  (HEX_EN),
    .pattern (pattern_s)
  );

`ifdef SEVEN_SEG_LZB_EN
  // Blank a zero digit when every more-significant digit is zero; digit 0 always shows
  always_comb begin
    logic zeros_above;
    zeros_above = 1'b1;
    blank_s     = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zeros_above = zeros_above && (digits_r[4*i +: 4] == 4'd0);
      blank_s     = blank_s | ((next_idx_s == IW'(i)) && (i != 0) && zeros_above);
    end
  end
`else
  assign blank_s = 1'b0;
`endif

  assign seg_next_s = blank_s ? SEG_BLANK : pattern_s;

  // Latch, prescale and advance the scan; seg/an update together on the tick edge
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_r  <= '0;
      idx_r        <= '0;
      digits_r     <= '0;
      seg_r        <= SEG_BLANK;
      an_r         <= '1;
      frame_done_r <= 1'b0;
    end else begin
      if (bus.load) begin
        digits_r <= bus.digits_in;
      end
      if (bus.en) begin
        if (tick_s) begin
          prescaler_r  <= '0;
          idx_r        <= next_idx_s;
          an_r         <= an_next_s;
          seg_r        <= seg_next_s;
          frame_done_r <= (next_idx_s == IW'(0));
        end else begin
          prescaler_r  <= prescaler_r + PW'(1);
          frame_done_r <= 1'b0;
        end
      end else begin
        seg_r        <= SEG_BLANK;
        an_r         <= '1;
        frame_done_r <= 1'b0;
      end
    end
  end

  assign bus.seg        = seg_r;
  assign bus.an         = an_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Directed bench: two 4-digit, CLK_DIV=4 instances (decimal and hex mode) driven in parallel.
module tb_seven_segment_scan;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] P0 = 7'b0000001;
  localparam logic [6:0] P1 = 7'b1001111;
  localparam logic [6:0] P2 = 7'b0010010;
  localparam logic [6:0] P3 = 7'b0000110;
  localparam logic [6:0] P4 = 7'b1001100;
  localparam logic [6:0] P7 = 7'b0001111;
  localparam logic [6:0] P9 = 7'b0000100;
  localparam logic [6:0] PA = 7'b0001000;
  localparam logic [6:0] PB = 7'b1100000;
  localparam logic [6:0] PC = 7'b0110001;
  localparam logic [6:0] PF = 7'b0111000;
`ifdef SEVEN_SEG_LZB_EN
  localparam logic [6:0] ZB = 7'b1111111;
`else
  localparam logic [6:0] ZB = 7'b0000001;
`endif

  logic        clk;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] digits;
  int          total;
  int          bad;

  seven_segment_scan_if #(.NUM_DIGITS(4)) bus_a ();
  seven_segment_scan_if #(.NUM_DIGITS(4)) bus_b ();

  assign bus_a.en        = en;
  assign bus_a.load      = load;
  assign bus_a.digits_in = digits;
  assign bus_b.en        = en;
  assign bus_b.load      = load;
  assign bus_b.digits_in = digits;

  seven_segment_scan #(.NUM_DIGITS(4), .CLK_DIV(4), .HEX_MODE(0)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a.slave)
  );

  seven_segment_scan #(.NUM_DIGITS(4), .CLK_DIV(4), .HEX_MODE(1)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic start(input logic [15:0] d);
    rst = 1'b1; en = 1'b0; load = 1'b0;
    step();
    rst = 1'b0; en = 1'b1; load = 1'b1; digits = d;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; load = 1'b1; digits = 16'hFFFF;
    step();
    step();
    total++;
    if (bus_a.seg !== BL) begin bad++; $display("FAIL reset_seg got=%b want=%b", bus_a.seg, BL); end
    total++;
    if (bus_a.an !== 4'b1111) begin bad++; $display("FAIL reset_an got=%b want=1111", bus_a.an); end
    total++;
    if (bus_a.frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b want=0", bus_a.frame_done); end
    total++;
    if (bus_b.seg !== BL) begin bad++; $display("FAIL reset_seg_hex got=%b want=%b", bus_b.seg, BL); end
  endtask

  task automatic test_scan();
    logic [6:0] pat [4];
    logic [3:0] ea;
    logic [6:0] es;
    logic       ef;
    int         ix;
    pat[0] = P4; pat[1] = P3; pat[2] = P2; pat[3] = P1;
    start(16'h1234);
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) step();
      if (k < 4) begin
        ea = 4'b1111; es = BL;
      end else begin
        ix = (k / 4) % 4;
        ea = ~(4'b0001 << ix);
        es = pat[ix];
      end
      ef = (k == 16);
      total++;
      if (bus_a.an !== ea) begin bad++; $display("FAIL scan_an k=%0d got=%b want=%b", k, bus_a.an, ea); end
      total++;
      if (bus_a.seg !== es) begin bad++; $display("FAIL scan_seg k=%0d got=%b want=%b", k, bus_a.seg, es); end
      total++;
      if (bus_a.frame_done !== ef) begin bad++; $display("FAIL scan_fd k=%0d got=%b want=%b", k, bus_a.frame_done, ef); end
    end
  endtask

  task automatic test_hex();
    logic [6:0] pat [4];
    logic [3:0] ea;
    int         ix;
    pat[0] = PF; pat[1] = PC; pat[2] = PB; pat[3] = PA;
    start(16'hABCF);
    for (int k = 2; k <= 16; k++) begin
      step();
      if ((k % 4) == 0) begin
        ix = (k / 4) % 4;
        ea = ~(4'b0001 << ix);
        total++;
        if (bus_b.an !== ea) begin bad++; $display("FAIL hex_an k=%0d got=%b want=%b", k, bus_b.an, ea); end
        total++;
        if (bus_b.seg !== pat[ix]) begin bad++; $display("FAIL hex_seg k=%0d got=%b want=%b", k, bus_b.seg, pat[ix]); end
        total++;
        if (bus_a.seg !== BL) begin bad++; $display("FAIL hexoff_seg k=%0d got=%b want=%b", k, bus_a.seg, BL); end
        total++;
        if (bus_a.an !== ea) begin bad++; $display("FAIL hexoff_an k=%0d got=%b want=%b", k, bus_a.an, ea); end
      end
    end
  endtask

  task automatic test_en_drop();
    start(16'h1234);
    for (int k = 2; k <= 6; k++) step();
    en = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      step();
      total++;
      if (bus_a.an !== 4'b1111) begin bad++; $display("FAIL endrop_an j=%0d got=%b want=1111", j, bus_a.an); end
      total++;
      if (bus_a.seg !== BL) begin bad++; $display("FAIL endrop_seg j=%0d got=%b want=%b", j, bus_a.seg, BL); end
      total++;
      if (bus_a.frame_done !== 1'b0) begin bad++; $display("FAIL endrop_fd j=%0d got=%b want=0", j, bus_a.frame_done); end
    end
    en = 1'b1;
    step();
    total++;
    if (bus_a.an !== 4'b1111) begin bad++; $display("FAIL resume_dark got=%b want=1111", bus_a.an); end
    for (int j = 0; j < 4; j++) begin
      step();
      total++;
      if (bus_a.an !== 4'b1011) begin bad++; $display("FAIL resume_an j=%0d got=%b want=1011", j, bus_a.an); end
      total++;
      if (bus_a.seg !== P2) begin bad++; $display("FAIL resume_seg j=%0d got=%b want=%b", j, bus_a.seg, P2); end
    end
    step();
    total++;
    if (bus_a.an !== 4'b0111) begin bad++; $display("FAIL resume_next_an got=%b want=0111", bus_a.an); end
    total++;
    if (bus_a.seg !== P1) begin bad++; $display("FAIL resume_next_seg got=%b want=%b", bus_a.seg, P1); end
  endtask

  task automatic test_load_on_tick();
    start(16'h1234);
    step();
    step();
    load = 1'b1; digits = 16'h9999;
    for (int j = 0; j < 4; j++) begin
      step();
      load = 1'b0;
      total++;
      if (bus_a.an !== 4'b1101) begin bad++; $display("FAIL ldtick_an j=%0d got=%b want=1101", j, bus_a.an); end
      total++;
      if (bus_a.seg !== P3) begin bad++; $display("FAIL ldtick_seg j=%0d got=%b want=%b", j, bus_a.seg, P3); end
    end
    step();
    total++;
    if (bus_a.an !== 4'b1011) begin bad++; $display("FAIL ldnext_an got=%b want=1011", bus_a.an); end
    total++;
    if (bus_a.seg !== P9) begin bad++; $display("FAIL ldnext_seg got=%b want=%b", bus_a.seg, P9); end
  endtask

  task automatic test_rst_mid();
    logic [3:0] ea;
    logic [6:0] es;
    int         ix;
    start(16'h1234);
    for (int k = 2; k <= 10; k++) step();
    rst = 1'b1; load = 1'b1; digits = 16'h5555; en = 1'b1;
    step();
    total++;
    if (bus_a.seg !== BL) begin bad++; $display("FAIL rstmid_seg got=%b want=%b", bus_a.seg, BL); end
    total++;
    if (bus_a.an !== 4'b1111) begin bad++; $display("FAIL rstmid_an got=%b want=1111", bus_a.an); end
    total++;
    if (bus_a.frame_done !== 1'b0) begin bad++; $display("FAIL rstmid_fd got=%b want=0", bus_a.frame_done); end
    rst = 1'b0; load = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      step();
      if (j < 4) begin
        ea = 4'b1111; es = BL;
      end else begin
        ix = (j / 4) % 4;
        ea = ~(4'b0001 << ix);
        es = (ix == 0) ? P0 : ZB;
      end
      total++;
      if (bus_a.an !== ea) begin bad++; $display("FAIL rstrun_an j=%0d got=%b want=%b", j, bus_a.an, ea); end
      total++;
      if (bus_a.seg !== es) begin bad++; $display("FAIL rstrun_seg j=%0d got=%b want=%b", j, bus_a.seg, es); end
      total++;
      if (bus_a.frame_done !== (j == 16)) begin bad++; $display("FAIL rstrun_fd j=%0d got=%b want=%b", j, bus_a.frame_done, (j == 16)); end
    end
  endtask

  task automatic test_lzb();
    logic [6:0] pat [4];
    logic [3:0] ea;
    int         ix;
    for (int run = 0; run < 2; run++) begin
      pat[0] = P0; pat[2] = ZB; pat[3] = ZB;
      if (run == 0) begin
        pat[1] = P7;
        start(16'h0070);
      end else begin
        pat[1] = ZB;
        start(16'h0000);
      end
      for (int k = 2; k <= 16; k++) begin
        step();
        if ((k % 4) == 0) begin
          ix = (k / 4) % 4;
          ea = ~(4'b0001 << ix);
          total++;
          if (bus_a.an !== ea) begin bad++; $display("FAIL lzb_an run=%0d k=%0d got=%b want=%b", run, k, bus_a.an, ea); end
          total++;
          if (bus_a.seg !== pat[ix]) begin bad++; $display("FAIL lzb_seg run=%0d k=%0d got=%b want=%b", run, k, bus_a.seg, pat[ix]); end
          total++;
          if (bus_b.seg !== pat[ix]) begin bad++; $display("FAIL lzb_seg_hex run=%0d k=%0d got=%b want=%b", run, k, bus_b.seg, pat[ix]); end
        end
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; en = 1'b0; load = 1'b0; digits = 16'h0000;
    @(negedge clk);
    test_reset();
    test_scan();
    test_hex();
    test_en_drop();
    test_load_on_tick();
    test_rst_mid();
    test_lzb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
